// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file: merges ALU results and
// handshaked load results onto the single write port, buffering late loads.
module regfile_writeback #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [4:0]    ld_rd,
    input  logic [31:0]   ld_data,
    output logic          we,
    output logic [4:0]    wa,
    output logic [31:0]   wd,
    output logic [31:0]   pending_mask,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    rptr, wptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] e_valid, e_kill;
    logic [4:0]       e_rd   [DEPTH];
    logic [31:0]      e_data [DEPTH];

    logic alu_go, ld_acc, ld_kill, fifo_empty, pop, wt, push, head_live;

    always_comb begin
        alu_go     = alu_valid && !stall && (alu_rd != 5'd0);
        ld_ready   = !rst && (count < CW'(DEPTH));
        ld_acc     = ld_valid && ld_ready;
        // The ALU result is always younger than any load, so it wins WAW.
        ld_kill    = alu_go && (ld_rd == alu_rd);
        fifo_empty = (count == '0);
        pop        = !alu_go && !fifo_empty;
        wt         = !alu_go && fifo_empty && ld_acc && (ld_rd != 5'd0);
        push       = ld_acc && !wt;
        head_live  = e_valid[rptr] && !e_kill[rptr] && (e_rd[rptr] != 5'd0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            e_valid <= '0;
            e_kill  <= '0;
            we      <= 1'b0;
            wa      <= 5'd0;
            wd      <= 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_go && e_valid[i] && (e_rd[i] == alu_rd))
                    e_kill[i] <= 1'b1;
            end

            if (pop) begin
                e_valid[rptr] <= 1'b0;
                rptr          <= rptr + AW'(1);
            end
            if (push) begin
                e_valid[wptr] <= 1'b1;
                e_kill[wptr]  <= ld_kill;
                wptr          <= wptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            we <= 1'b0;
            if (alu_go) begin
                we <= 1'b1;
                wa <= alu_rd;
                wd <= alu_data;
            end else if (pop) begin
                if (head_live) begin
                    we <= 1'b1;
                    wa <= e_rd[rptr];
                    wd <= e_data[rptr];
                end
            end else if (wt) begin
                we <= 1'b1;
                wa <= ld_rd;
                wd <= ld_data;
            end
        end
    end

    // NOTE: payload storage is not reset; the reset valid bits already make
    // every entry dead, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            e_rd[wptr]   <= ld_rd;
            e_data[wptr] <= ld_data;
        end
    end

    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && !e_kill[i])
                pending_mask[e_rd[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed stimulus queues expected
// writes, a negedge monitor checks every we pulse against the queue.
module tb_regfile_writeback;

    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [31:0]   ld_data;
    logic          we;
    logic [4:0]    wa;
    logic [31:0]   wd;
    logic [31:0]   pending_mask;
    logic [CW-1:0] fifo_count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    regfile_writeback #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .we(we), .wa(wa), .wd(wd),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    // Monitor: every write-port pulse must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && we) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got wa=%0d wd=0x%08h, expected no write", wa, wd);
                end else begin
                    e = exp_q.pop_front();
                    check("write_wa", 32'(wa), 32'(e.rd));
                    check("write_wd", wd, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b0, 5'd0, 32'd0);
        step();
        step();
        check("reset_we", 32'(we), 32'd0);
        check("reset_wa_wd", {27'd0, wa} | wd, 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_mask", pending_mask, 32'd0);
        check("reset_ld_ready", 32'(ld_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_ld_ready", 32'(ld_ready), 32'd1);

        // ALU only, then an x0 result that must not write.
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        check("alu_we", 32'(we), 32'd1);
        alu(1'b1, 5'd0, 32'h0000_0001);
        step();
        check("alu_x0_no_write", 32'(we), 32'd0);
        alu(1'b0, 5'd0, 32'd0);

        // Load write-through on an empty FIFO.
        ld(1'b1, 5'd7, 32'h0000_1234);
        expect_wr(5'd7, 32'h0000_1234);
        step();
        ld(1'b0, 5'd0, 32'd0);
        check("wt_we", 32'(we), 32'd1);
        check("wt_count", 32'(fifo_count), 32'd0);

        // Contention: ALU busy every cycle, two loads buffer, a third waits.
        alu(1'b1, 5'd1, 32'h11);
        ld(1'b1, 5'd10, 32'hA0);
        expect_wr(5'd1, 32'h11);
        step();
        alu(1'b1, 5'd2, 32'h22);
        ld(1'b1, 5'd11, 32'hB0);
        expect_wr(5'd2, 32'h22);
        step();
        check("cont_count2", 32'(fifo_count), 32'd2);
        check("cont_ld_ready", 32'(ld_ready), 32'd0);
        check("cont_mask", pending_mask, 32'h0000_0C00);
        ld(1'b1, 5'd12, 32'hC0);
        for (int r = 3; r <= 6; r++) begin
            alu(1'b1, 5'(r), 32'(r * 32'h11));
            expect_wr(5'(r), 32'(r * 32'h11));
            step();
        end
        check("cont_full_hold", 32'(fifo_count), 32'd2);
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b0, 5'd0, 32'd0);
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd11, 32'hB0);
        step();
        check("drain_count1", 32'(fifo_count), 32'd1);
        check("drain_first_wa", 32'(wa), 32'd10);
        step();
        check("drain_count0", 32'(fifo_count), 32'd0);
        check("drain_second_wa", 32'(wa), 32'd11);
        step();

        // WAW kill of a buffered load.
        alu(1'b1, 5'd8, 32'h88);
        ld(1'b1, 5'd9, 32'h99);
        expect_wr(5'd8, 32'h88);
        step();
        ld(1'b0, 5'd0, 32'd0);
        check("waw_mask_set", pending_mask, 32'h0000_0200);
        alu(1'b1, 5'd9, 32'hAAAA);
        expect_wr(5'd9, 32'hAAAA);
        step();
        check("waw_mask_clear", pending_mask, 32'd0);
        check("waw_count_held", 32'(fifo_count), 32'd1);
        alu(1'b0, 5'd0, 32'd0);
        step();
        check("waw_killed_pop_we", 32'(we), 32'd0);
        check("waw_count0", 32'(fifo_count), 32'd0);

        // Incoming load killed by a same-cycle ALU write to the same register.
        alu(1'b1, 5'd13, 32'hD);
        ld(1'b1, 5'd13, 32'h1313);
        expect_wr(5'd13, 32'hD);
        step();
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b0, 5'd0, 32'd0);
        check("inkill_count", 32'(fifo_count), 32'd1);
        check("inkill_mask", pending_mask, 32'd0);
        step();
        check("inkill_pop_we", 32'(we), 32'd0);

        // Stall blocks the ALU but the FIFO keeps draining.
        alu(1'b1, 5'd2, 32'h2222);
        ld(1'b1, 5'd4, 32'h44);
        expect_wr(5'd2, 32'h2222);
        step();
        ld(1'b0, 5'd0, 32'd0);
        stall = 1'b1;
        alu(1'b1, 5'd3, 32'h3333);
        expect_wr(5'd4, 32'h44);
        step();
        check("stall_drain_wa", 32'(wa), 32'd4);
        step();
        check("stall_no_alu_we", 32'(we), 32'd0);
        stall = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        step();

        // Reset mid-stream with two loads buffered.
        alu(1'b1, 5'd1, 32'h1);
        ld(1'b1, 5'd20, 32'h20);
        expect_wr(5'd1, 32'h1);
        step();
        alu(1'b1, 5'd2, 32'h2);
        ld(1'b1, 5'd21, 32'h21);
        expect_wr(5'd2, 32'h2);
        step();
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b0, 5'd0, 32'd0);
        check("rst_pre_count", 32'(fifo_count), 32'd2);
        check("rst_pre_mask", pending_mask, 32'h0030_0000);
        #5;
        rst = 1'b1;
        #1;
        check("rst_async_we", 32'(we), 32'd0);
        check("rst_async_count", 32'(fifo_count), 32'd0);
        check("rst_async_mask", pending_mask, 32'd0);
        check("rst_async_ld_ready", 32'(ld_ready), 32'd0);
        step();
        step();
        check("rst_hold_ld_ready", 32'(ld_ready), 32'd0);
        rst = 1'b0;
        step();
        check("rst_release_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_release_count", 32'(fifo_count), 32'd0);
        step();
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
